// File: rtl/alu_pkg.sv
// Shared definitions for the ALU slice and its downstream stages.
package alu_pkg;

    localparam int unsigned WIDTH    = 5;
    localparam int unsigned ADDR_W   = 3;

    // Bit positions inside the packed {cf,sf,zf} flags vector
    localparam int unsigned FLAG_CF  = 2;
    localparam int unsigned FLAG_SF  = 1;
    localparam int unsigned FLAG_ZF  = 0;

    // Branch condition selector: [1:0] picks the flag, [COND_INV] inverts it
    localparam logic [1:0]  COND_ALWAYS = 2'b00;
    localparam logic [1:0]  COND_Z      = 2'b01;
    localparam logic [1:0]  COND_S      = 2'b10;
    localparam logic [1:0]  COND_C      = 2'b11;
    localparam int unsigned COND_INV    = 2;

    typedef struct packed {
        logic cf;
        logic sf;
        logic zf;
    } flags_t;

    // Bundle the three ALU flags in architectural order
    function automatic flags_t make_flags(input logic cf, input logic sf, input logic zf);
        flags_t f;
        f.cf = cf;
        f.sf = sf;
        f.zf = zf;
        return f;
    endfunction

endpackage

// File: rtl/alu_result_stage_if.sv
// Result-in / writeback-out handshake bundle of the ALU result stage.
interface alu_result_stage_if #(
    parameter int unsigned WIDTH  = alu_pkg::WIDTH,
    parameter int unsigned ADDR_W = alu_pkg::ADDR_W
);
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_z;
    logic              in_cf;
    logic              in_sf;
    logic              in_zf;
    logic [ADDR_W-1:0] in_dest;
    logic              in_wflags;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_data;
    logic [ADDR_W-1:0] out_dest;

    // Environment side: ALU producer plus writeback consumer
    modport master (
        output in_valid, in_z, in_cf, in_sf, in_zf, in_dest, in_wflags, out_ready,
        input  in_ready, out_valid, out_data, out_dest
    );

    // Stage side
    modport slave (
        input  in_valid, in_z, in_cf, in_sf, in_zf, in_dest, in_wflags, out_ready,
        output in_ready, out_valid, out_data, out_dest
    );
endinterface

// File: rtl/cond_eval.sv
// Branch condition evaluation on a committed flags vector; shared with the branch unit.
module cond_eval
    import alu_pkg::*;
(
    input  logic [2:0] flags,
    input  logic [2:0] cond_sel,
    output logic       cond_true
);

    logic base;

    // Select the tested flag, then apply the optional inversion
    always_comb begin
        base = 1'b1;
        case (cond_sel[1:0])
            COND_ALWAYS: base = 1'b1;
            COND_Z:      base = flags[FLAG_ZF];
            COND_S:      base = flags[FLAG_SF];
            COND_C:      base = flags[FLAG_CF];
            default:     base = 1'b1;
        endcase
        cond_true = base ^ cond_sel[COND_INV];
    end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: 2-entry skid buffer toward writeback, flag commit on retire,
// and branch condition evaluation on the committed flags.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH  = 5,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned DEPTH  = 2
)(
    input  logic                clk,
    input  logic                rst,
    alu_result_stage_if.slave   bus,
    output logic [2:0]          flags_q,
    input  logic [2:0]          cond_sel,
    output logic                cond_true
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [CNT_W-1:0]  count;
    logic              wr_ptr;
    logic              rd_ptr;
    logic [WIDTH-1:0]  data_mem   [2];
    logic [ADDR_W-1:0] dest_mem   [2];
    flags_t            flags_mem  [2];
    logic              wflags_mem [2];

    logic full;
    logic push;
    logic pop;

    // Handshake is derived from registered occupancy only; reset masks both sides
    assign full          = (count == CNT_W'(DEPTH));
    assign bus.in_ready  = ~rst & ~full;
    assign bus.out_valid = ~rst & (count != '0);
    assign bus.out_data  = data_mem[rd_ptr];
    assign bus.out_dest  = dest_mem[rd_ptr];

    assign push = bus.in_valid  & bus.in_ready;
    assign pop  = bus.out_valid & bus.out_ready;

    // Buffer storage, pointers, occupancy and architectural flags
    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            flags_q <= 3'b000;
            for (int i = 0; i < 2; i++) begin
                data_mem[i]   <= '0;
                dest_mem[i]   <= '0;
                flags_mem[i]  <= '0;
                wflags_mem[i] <= 1'b0;
            end
        end else begin
            if (push) begin
                data_mem[wr_ptr]   <= bus.in_z;
                dest_mem[wr_ptr]   <= bus.in_dest;
                flags_mem[wr_ptr]  <= make_flags(bus.in_cf, bus.in_sf, bus.in_zf);
                wflags_mem[wr_ptr] <= bus.in_wflags;
                wr_ptr             <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
                if (wflags_mem[rd_ptr]) begin
                    flags_q <= flags_mem[rd_ptr];
                end
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    cond_eval u_cond_eval (
        .flags     (flags_q),
        .cond_sel  (cond_sel),
        .cond_true (cond_true)
    );

endmodule

// File: tb/tb_alu_result_stage.sv
// Randomized + directed bench for alu_result_stage against a queue-based model.
module tb_alu_result_stage;

    logic       clk;
    logic       rst;
    logic [2:0] flags_q;
    logic [2:0] cond_sel;
    logic       cond_true;

    alu_result_stage_if #(.WIDTH(5), .ADDR_W(3)) bus ();

    alu_result_stage #(.WIDTH(5), .ADDR_W(3), .DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .flags_q   (flags_q),
        .cond_sel  (cond_sel),
        .cond_true (cond_true)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] z;
        logic [2:0] dest;
        logic [2:0] fl;
        logic       wf;
    } ent_t;

    ent_t       mq[$];
    logic [2:0] mflags  = 3'b000;
    bit         started = 1'b0;
    int         total   = 0;
    int         bad     = 0;
    int         popped[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic exp_cond(input logic [2:0] fl, input logic [2:0] sel);
        case (sel)
            3'd0: return 1'b1;
            3'd1: return fl[0];
            3'd2: return fl[1];
            3'd3: return fl[2];
            3'd4: return 1'b0;
            3'd5: return !fl[0];
            3'd6: return !fl[1];
            default: return !fl[2];
        endcase
    endfunction

    // Reference model: a FIFO of at most two entries plus a flags register
    task automatic model_step();
        bit   do_push;
        bit   do_pop;
        ent_t e;
        started = 1'b1;
        if (rst) begin
            mq.delete();
            mflags = 3'b000;
        end else begin
            do_push = bus.in_valid && (mq.size() < 2);
            do_pop  = bus.out_ready && (mq.size() > 0);
            if (do_pop) begin
                e = mq.pop_front();
                if (e.wf) mflags = e.fl;
            end
            if (do_push) begin
                e.z    = bus.in_z;
                e.dest = bus.in_dest;
                e.fl   = {bus.in_cf, bus.in_sf, bus.in_zf};
                e.wf   = bus.in_wflags;
                mq.push_back(e);
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle comparison on the falling edge
    initial forever begin
        @(negedge clk);
        if (started) begin
            chk("in_ready",  32'(bus.in_ready),  32'(!rst && mq.size() < 2));
            chk("out_valid", 32'(bus.out_valid), 32'(!rst && mq.size() > 0));
            if (!rst && mq.size() > 0) begin
                chk("out_data", 32'(bus.out_data), 32'(mq[0].z));
                chk("out_dest", 32'(bus.out_dest), 32'(mq[0].dest));
            end
            chk("flags_q",   32'(flags_q),   32'(mflags));
            chk("cond_true", 32'(cond_true), 32'(exp_cond(mflags, cond_sel)));
            if (!rst && bus.out_valid && bus.out_ready) popped.push_back(int'(bus.out_data));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [4:0] z, input logic [2:0] dest, input logic [2:0] fl, input logic wf);
        bus.in_valid  = 1'b1;
        bus.in_z      = z;
        bus.in_dest   = dest;
        bus.in_cf     = fl[2];
        bus.in_sf     = fl[1];
        bus.in_zf     = fl[0];
        bus.in_wflags = wf;
    endtask

    initial begin
        rst           = 1'b1;
        cond_sel      = 3'b000;
        bus.out_ready = 1'b0;
        put(5'd0, 3'd0, 3'b000, 1'b0);

        // Reset held two cycles with in_valid high
        cyc();
        chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_flags",     32'(flags_q),       32'd0);
        cyc();
        chk("rst2_in_ready", 32'(bus.in_ready),  32'd0);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("rel_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rel_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rel_out_data",  32'(bus.out_data),  32'd0);
        chk("rel_out_dest",  32'(bus.out_dest),  32'd0);

        // Single op with flag commit
        put(5'b10100, 3'd3, 3'b010, 1'b1);
        bus.out_ready = 1'b1;
        cond_sel      = 3'b010;
        cyc();
        bus.in_valid = 1'b0;
        chk("single_valid", 32'(bus.out_valid), 32'd1);
        chk("single_data",  32'(bus.out_data),  32'h14);
        chk("single_dest",  32'(bus.out_dest),  32'd3);
        cyc();
        chk("single_flags", 32'(flags_q),       32'h2);
        chk("single_cond",  32'(cond_true),     32'd1);
        chk("single_empty", 32'(bus.out_valid), 32'd0);

        // Backpressure: fill, reject third, then drain in order
        popped.delete();
        bus.out_ready = 1'b0;
        put(5'd1, 3'd1, 3'b000, 1'b0);
        cyc();
        put(5'd2, 3'd2, 3'b000, 1'b0);
        cyc();
        chk("bp_full_rdy", 32'(bus.in_ready), 32'd0);
        put(5'd3, 3'd4, 3'b000, 1'b0);
        cyc();
        chk("bp_hold_data", 32'(bus.out_data), 32'd1);
        bus.out_ready = 1'b1;
        cyc();
        cyc();
        bus.in_valid = 1'b0;
        cyc();
        cyc();
        chk("bp_count", 32'(popped.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk("bp_order", (i < popped.size()) ? 32'(popped[i]) : 32'hdead, 32'(i + 1));
        end

        // Simultaneous push and pop at count=1
        bus.out_ready = 1'b0;
        put(5'd6, 3'd5, 3'b000, 1'b0);
        cyc();
        put(5'd7, 3'd6, 3'b000, 1'b0);
        bus.out_ready = 1'b1;
        cyc();
        bus.in_valid = 1'b0;
        chk("sim_valid", 32'(bus.out_valid), 32'd1);
        chk("sim_data",  32'(bus.out_data),  32'd7);
        chk("sim_rdy",   32'(bus.in_ready),  32'd1);
        cyc();

        // wflags=0 retirement leaves committed flags untouched
        put(5'd0, 3'd1, 3'b001, 1'b1);
        cyc();
        bus.in_valid = 1'b0;
        cyc();
        chk("wf_commit", 32'(flags_q), 32'h1);
        put(5'd3, 3'd2, 3'b000, 1'b0);
        cond_sel = 3'b101;
        cyc();
        bus.in_valid = 1'b0;
        cyc();
        chk("wf0_flags", 32'(flags_q),   32'h1);
        chk("wf0_cond",  32'(cond_true), 32'd0);

        // Reset with two entries buffered and flags=111
        put(5'd31, 3'd7, 3'b111, 1'b1);
        cyc();
        bus.in_valid = 1'b0;
        cyc();
        chk("mr_flags_pre", 32'(flags_q), 32'h7);
        bus.out_ready = 1'b0;
        put(5'd9, 3'd1, 3'b000, 1'b1);
        cyc();
        put(5'd10, 3'd2, 3'b000, 1'b1);
        cyc();
        bus.in_valid = 1'b0;
        chk("mr_full", 32'(bus.in_ready), 32'd0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk("mr_valid", 32'(bus.out_valid), 32'd0);
        chk("mr_flags", 32'(flags_q),       32'd0);
        chk("mr_rdy",   32'(bus.in_ready),  32'd1);
        popped.delete();
        bus.out_ready = 1'b1;
        cyc();
        cyc();
        cyc();
        chk("mr_no_stale", 32'(popped.size()), 32'd0);

        // Random traffic with occasional reset
        for (int i = 0; i < 600; i++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.in_z      = 5'($urandom_range(0, 31));
            bus.in_dest   = 3'($urandom_range(0, 7));
            bus.in_cf     = 1'($urandom_range(0, 1));
            bus.in_sf     = 1'($urandom_range(0, 1));
            bus.in_zf     = 1'($urandom_range(0, 1));
            bus.in_wflags = 1'($urandom_range(0, 1));
            bus.out_ready = 1'($urandom_range(0, 3) != 0);
            cond_sel      = 3'($urandom_range(0, 7));
            rst           = ($urandom_range(0, 49) == 0);
            cyc();
        end

        // Drain
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        cyc();
        cyc();
        cyc();
        chk("drain_empty", 32'(bus.out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Downstream stage of the 5-bit ALU slice. It captures the slice's result (z) and flags (cf, sf, zf) together with a destination tag.
- It buffers them in a 2-entry skid FIFO with a valid/ready handshake toward the register-file writeback port.
- It commits flags into an architectural flags register when each entry retires.
- It evaluates a branch condition against the committed flags for the control unit.

Parameters:
- WIDTH, 5, datapath width of result and writeback data
- ADDR_W, 3, destination register index width
- DEPTH, 2, buffer entries; fixed at 2, other values unsupported

Ports:
- clk  in  1  single system clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  ALU result presented this cycle
- in_ready  out  1  stage can accept an entry this cycle
- in_z  in  WIDTH  ALU result
- in_cf  in  1  carry flag from ALU
- in_sf  in  1  sign flag from ALU
- in_zf  in  1  zero flag from ALU
- in_dest  in  ADDR_W  destination register index
- in_wflags  in  1  1 = this op updates the flags register
- out_valid  out  1  head entry available for writeback
- out_ready  in  1  writeback port accepts head entry
- out_data  out  WIDTH  head entry result
- out_dest  out  ADDR_W  head entry destination
- flags_q  out  3  committed flags {cf,sf,zf}
- cond_sel  in  3  [1:0] 00=always, 01=ZF, 10=SF, 11=CF; [2]=invert
- cond_true  out  1  condition evaluated on flags_q

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, on rst. All state is sampled on the rising edge of clk.
- Reset values:
  - count=0, read/write pointers=0.
  - out_valid=0, out_data=0, out_dest=0.
  - flags_q=3'b000.
  - in_ready=0 while rst=1, and 1 in the first cycle after rst deasserts.
- Push and pop:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_ready = ~rst & (count < 2). It is registered-derived and must not depend combinationally on out_ready.
  - out_valid = (count != 0). out_data and out_dest always show the head entry, and are held stable while out_valid=1 and out_ready=0.
- Latency: an entry pushed in cycle N appears on out_valid/out_data in cycle N+1, or later if older entries remain. There is no combinational in-to-out path.
- Simultaneous push and pop:
  - count is unchanged and both pointers advance.
  - Legal at count=1, and at count=2 only if in_ready is already 1; it is 0 when full, so no push occurs at count=2.
- Full (count=2): in_ready=0, and in_valid is ignored with no data loss on the ALU side.
- Empty (count=0): out_valid=0, pop is impossible, and out_ready is ignored.
- Pointers: 1-bit each, wrap 1->0.
- Flag commit: on the cycle of a pop whose entry has wflags=1, flags_q <= that entry's {cf,sf,zf}. The new value is visible in cycle N+1. Pops with wflags=0 leave flags_q unchanged.
- cond_true is combinational from flags_q and cond_sel: base = 1 / zf / sf / cf, then XOR with cond_sel[2]. Always with invert gives 0.
- Reset mid-operation: all buffered entries are discarded without writeback. flags_q clears, and there is no pop during the reset cycle.
- The input flags are stored as given; this stage does not recompute them from in_z.

Decomposition:
- Shared package alu_pkg:
  - WIDTH and ADDR_W defaults.
  - Flag bit indices FLAG_CF=2, FLAG_SF=1, FLAG_ZF=0.
  - Condition codes COND_ALWAYS, COND_Z, COND_S, COND_C and COND_INV bit position.
- Sub-module cond_eval: the combinational flags/cond_sel -> cond_true logic, reused by the branch unit.
- Buffer storage and pointers stay inline.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1 -> in_ready=0, out_valid=0, flags_q=000 throughout. Cycle after release -> in_ready=1.
- Single op: push z=5'b10100, cf=0, sf=1, zf=0, dest=3, wflags=1 with out_ready=1 -> out_valid=1, out_data=10100, out_dest=3 next cycle. flags_q=010 one cycle after the pop. cond_sel=010 -> cond_true=1.
- Backpressure: out_ready=0, push z=1 then z=2 -> in_ready=0 after the second push. A third in_valid with z=3 is not accepted. Raise out_ready -> outputs 1, 2, then 3 in order with no loss or duplication.
- Simultaneous: at count=1, push z=7 and pop in the same cycle -> count stays 1, next head is z=7.
- wflags=0 pop: commit zf=1 first, then pop an entry with zf=0, wflags=0 -> flags_q stays 001. cond_sel=101 -> cond_true=0.
- Mid-operation reset: with 2 entries buffered and flags_q=111, assert rst for 1 cycle -> out_valid=0, flags_q=000, and no stale entry emerges afterwards.
